// File: rtl/balu_ise_pkg.sv
// Shared constants, decode function and rotate helpers for balu_ise and its dispatch stage.
package balu_ise_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned FN_W = 6;

    localparam logic [FN_W-1:0] FN_ROR   = 6'd32;
    localparam logic [FN_W-1:0] FN_ROL   = 6'd33;
    localparam logic [FN_W-1:0] FN_RORI  = 6'd34;
    localparam logic [FN_W-1:0] FN_ANDN  = 6'd35;
    localparam logic [FN_W-1:0] FN_ORN   = 6'd36;
    localparam logic [FN_W-1:0] FN_XNOR  = 6'd37;
    localparam logic [FN_W-1:0] FN_PACK  = 6'd38;
    localparam logic [FN_W-1:0] FN_PACKH = 6'd39;
    localparam logic [FN_W-1:0] FN_RORW  = 6'd40;
    localparam logic [FN_W-1:0] FN_ROLW  = 6'd41;
    localparam logic [FN_W-1:0] FN_RORIW = 6'd42;
    localparam logic [FN_W-1:0] FN_PACKW = 6'd43;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    localparam logic [2:0] F3_ROR   = 3'b101;
    localparam logic [2:0] F3_ROL   = 3'b001;
    localparam logic [2:0] F3_ANDN  = 3'b111;
    localparam logic [2:0] F3_ORN   = 3'b110;
    localparam logic [2:0] F3_XNOR  = 3'b100;
    localparam logic [2:0] F3_PACK  = 3'b100;
    localparam logic [2:0] F3_PACKH = 3'b111;

    localparam logic [6:0] F7_ROT  = 7'b0110000;
    localparam logic [6:0] F7_LOGN = 7'b0100000;
    localparam logic [6:0] F7_PACK = 7'b0000100;
    localparam logic [5:0] F6_RORI = 6'b011000;

    typedef struct packed {
        logic            illegal;
        logic [FN_W-1:0] fn;
        logic            use_imm;
    } dec_t;

    // Map a raw instruction word onto a balu_ise function code.
    function automatic dec_t decode_zbkb(input logic [31:0] insn);
        dec_t d;
        d.illegal = 1'b0;
        d.fn      = '0;
        d.use_imm = 1'b0;
        case (insn[6:0])
            OPC_OP: begin
                case ({insn[31:25], insn[14:12]})
                    {F7_ROT,  F3_ROR}:   d.fn = FN_ROR;
                    {F7_ROT,  F3_ROL}:   d.fn = FN_ROL;
                    {F7_LOGN, F3_ANDN}:  d.fn = FN_ANDN;
                    {F7_LOGN, F3_ORN}:   d.fn = FN_ORN;
                    {F7_LOGN, F3_XNOR}:  d.fn = FN_XNOR;
                    {F7_PACK, F3_PACK}:  d.fn = FN_PACK;
                    {F7_PACK, F3_PACKH}: d.fn = FN_PACKH;
                    default:             d.illegal = 1'b1;
                endcase
            end
            OPC_OP_32: begin
                case ({insn[31:25], insn[14:12]})
                    {F7_ROT,  F3_ROR}:  d.fn = FN_RORW;
                    {F7_ROT,  F3_ROL}:  d.fn = FN_ROLW;
                    {F7_PACK, F3_PACK}: d.fn = FN_PACKW;
                    default:            d.illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                if (insn[31:26] == F6_RORI && insn[14:12] == F3_ROR) begin
                    d.fn      = FN_RORI;
                    d.use_imm = 1'b1;
                end else begin
                    d.illegal = 1'b1;
                end
            end
            OPC_OP_IMM_32: begin
                // shamt[5] set lands in funct7 and therefore fails this match
                if (insn[31:25] == F7_ROT && insn[14:12] == F3_ROR) begin
                    d.fn      = FN_RORIW;
                    d.use_imm = 1'b1;
                end else begin
                    d.illegal = 1'b1;
                end
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input logic [5:0] s);
        return (x >> s) | (x << (7'd64 - {1'b0, s}));
    endfunction

    function automatic logic [63:0] rol64(input logic [63:0] x, input logic [5:0] s);
        return (x << s) | (x >> (7'd64 - {1'b0, s}));
    endfunction

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] s);
        return (x >> s) | (x << (6'd32 - {1'b0, s}));
    endfunction

    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] s);
        return (x << s) | (x >> (6'd32 - {1'b0, s}));
    endfunction

endpackage

// File: rtl/balu_ise.sv
// Combinational Zbkb bit-manipulation unit; word ops return a zero-extended 32-bit result.
module balu_ise
    import balu_ise_pkg::*;
(
    input  logic            ise_val,
    input  logic [FN_W-1:0] ise_fn,
    input  logic [XLEN-1:0] ise_rs1,
    input  logic [XLEN-1:0] ise_rs2,
    output logic            ise_oval,
    output logic [XLEN-1:0] ise_out
);

    logic [XLEN-1:0] res_c;

    // Function select; immediate forms arrive with the shamt already in rs2.
    always_comb begin
        res_c = '0;
        case (ise_fn)
            FN_ROR:   res_c = ror64(ise_rs1, ise_rs2[5:0]);
            FN_ROL:   res_c = rol64(ise_rs1, ise_rs2[5:0]);
            FN_RORI:  res_c = ror64(ise_rs1, ise_rs2[5:0]);
            FN_ANDN:  res_c = ise_rs1 & ~ise_rs2;
            FN_ORN:   res_c = ise_rs1 | ~ise_rs2;
            FN_XNOR:  res_c = ~(ise_rs1 ^ ise_rs2);
            FN_PACK:  res_c = {ise_rs2[31:0], ise_rs1[31:0]};
            FN_PACKH: res_c = {48'd0, ise_rs2[7:0], ise_rs1[7:0]};
            FN_RORW:  res_c = {32'd0, ror32(ise_rs1[31:0], ise_rs2[4:0])};
            FN_ROLW:  res_c = {32'd0, rol32(ise_rs1[31:0], ise_rs2[4:0])};
            FN_RORIW: res_c = {32'd0, ror32(ise_rs1[31:0], ise_rs2[4:0])};
            FN_PACKW: res_c = {32'd0, ise_rs2[15:0], ise_rs1[15:0]};
            default:  res_c = '0;
        endcase
    end

    assign ise_oval = ise_val;
    assign ise_out  = ise_val ? res_c : '0;

endmodule

// File: rtl/balu_ise_dispatch.sv
// Two-stage issue pipe: decode into D, execute on balu_ise, register result in R for writeback.
module balu_ise_dispatch
    import balu_ise_pkg::*;
#(
    parameter int unsigned TAG_W = 5
) (
    input  logic             ise_clk,
    input  logic             ise_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_insn,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    dec_t            in_dec_c;
    logic [XLEN-1:0] in_op2_c;

    logic            d_valid;
    logic [FN_W-1:0] d_fn;
    logic [XLEN-1:0] d_rs1;
    logic [XLEN-1:0] d_op2;
    logic [TAG_W-1:0] d_tag;
    logic            d_illegal;

    logic            r_valid;
    logic [XLEN-1:0] r_result;
    logic [TAG_W-1:0] r_tag;
    logic            r_illegal;

    logic            r_ready_c;
    logic            d_ready_c;
    logic            ise_val;
    logic            ise_oval;
    logic [XLEN-1:0] ise_out;

    // Decode and operand-2 selection for the incoming instruction.
    always_comb begin
        in_dec_c = decode_zbkb(in_insn);
        in_op2_c = in_dec_c.use_imm ? {58'd0, in_insn[25:20]} : in_rs2;
    end

    // Ready chain depends only on stage occupancy and out_ready, never on in_valid.
    assign r_ready_c = ~r_valid | out_ready;
    assign d_ready_c = ~d_valid | r_ready_c;
    assign in_ready  = d_ready_c;

    // Stage D: capture decoded op; flush kills it regardless of handshakes.
    always_ff @(posedge ise_clk or negedge ise_rst) begin
        if (!ise_rst) begin
            d_valid   <= 1'b0;
            d_fn      <= '0;
            d_rs1     <= '0;
            d_op2     <= '0;
            d_tag     <= '0;
            d_illegal <= 1'b0;
        end else if (flush) begin
            d_valid <= 1'b0;
        end else if (d_ready_c) begin
            d_valid <= in_valid;
            if (in_valid) begin
                d_fn      <= in_dec_c.fn;
                d_rs1     <= in_rs1;
                d_op2     <= in_op2_c;
                d_tag     <= in_tag;
                d_illegal <= in_dec_c.illegal;
            end
        end
    end

    assign ise_val = d_valid & ~d_illegal;

    balu_ise u_balu_ise (
        .ise_val  (ise_val),
        .ise_fn   (d_fn),
        .ise_rs1  (d_rs1),
        .ise_rs2  (d_op2),
        .ise_oval (ise_oval),
        .ise_out  (ise_out)
    );

    // Stage R: hold result for writeback; illegal ops carry 0 since balu_ise is not enabled.
    always_ff @(posedge ise_clk or negedge ise_rst) begin
        if (!ise_rst) begin
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_tag     <= '0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (r_ready_c) begin
            r_valid <= d_valid;
            if (d_valid) begin
                r_result  <= ise_out;
                r_tag     <= d_tag;
                r_illegal <= d_illegal;
            end
        end
    end

    assign out_valid   = r_valid;
    assign out_result  = r_result;
    assign out_tag     = r_tag;
    assign out_illegal = r_illegal;

    // balu_ise's valid output is redundant with ise_val; only sanity-checked here.
    assert property (@(posedge ise_clk) disable iff (!ise_rst) ise_oval == ise_val);

endmodule
